// File: rtl/custom_ip_pkg.sv
// Shared definitions for the custom IP register arbiter.
// Holds the arbiter FSM state type and the default register file geometry.
package custom_ip_pkg;

    // Transaction sequencer states: grant, strobe/issue, readback wait, respond
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int DEFAULT_NUM_REGS = 3;
    localparam int DEFAULT_DATA_W   = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   valid  in   NUM_REQ  request valid vector
//   ptr    in   IDX_W    index of the highest-priority requester this round
//   grant  out  NUM_REQ  one-hot grant (all zero when nothing is valid)
//   idx    out  IDX_W    index of the granted requester
//   found  out  1        at least one requester is valid
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    int cand;

    // Scan requesters starting at ptr and wrapping; the first valid one wins.
    // ptr is always kept below NUM_REQ, so a single subtraction is enough to wrap.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/custom_ip_reg_arbiter.sv
// Shares the custom IP register port between NUM_REQ requesters, one
// transaction at a time, with round-robin fairness.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    per-requester request handshake (ready = grant)
//   req_we_i/addr_i/wdata_i    per-requester payload, flattened
//   rsp_valid_o/rsp_ready_i    per-requester response handshake
//   rsp_rdata_o/rsp_err_o      shared response data and bad-address flag
//   reg_wen_o/reg_wdata_o      one-hot write strobe and data into the IP
//   reg_rdata_i                IP readback, flattened
//   busy_o                     a transaction is in flight
module custom_ip_reg_arbiter
    import custom_ip_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    parameter int RD_LAT   = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ-1:0]         req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    input  logic [NUM_REQ-1:0]         rsp_ready_i,
    output logic [DATA_W-1:0]          rsp_rdata_o,
    output logic                       rsp_err_o,
    output logic [NUM_REGS-1:0]        reg_wen_o,
    output logic [DATA_W-1:0]          reg_wdata_o,
    input  logic [NUM_REGS*DATA_W-1:0] reg_rdata_i,
    output logic                       busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] WAIT_INIT = 3'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    arb_state_e          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    owner;
    logic                owner_we;
    logic [ADDR_W-1:0]   owner_addr;
    logic [2:0]          wait_cnt;

    logic [NUM_REQ-1:0]  win_grant;
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic                win_addr_ok;
    logic                owner_addr_ok;
    logic [IDX_W-1:0]    next_ptr;
    logic [DATA_W-1:0]   capture_data;
    logic                go_resp;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .valid (req_valid_i),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .found (win_found)
    );

    // Payload of the requester that would be accepted this cycle
    assign win_we      = req_we_i[win_idx];
    assign win_addr    = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
    assign win_wdata   = req_wdata_i[int'(win_idx)*DATA_W +: DATA_W];
    assign win_addr_ok = (int'(win_addr) < NUM_REGS);
    assign next_ptr    = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IDX_W'(1);

    assign owner_addr_ok = (int'(owner_addr) < NUM_REGS);

    // Writes and out-of-range reads answer with zero; the select is only
    // meaningful for in-range reads, so it is masked otherwise.
    assign capture_data = (!owner_we && owner_addr_ok)
                        ? reg_rdata_i[int'(owner_addr)*DATA_W +: DATA_W]
                        : '0;

    // RESP is entered straight from ISSUE unless a read must wait for the IP
    // readback to settle, in which case WAIT counts down first.
    assign go_resp = ((state == ISSUE) && (owner_we || (RD_LAT == 0))) ||
                     ((state == WAIT) && (wait_cnt == 3'd0));

    // Grant is combinational so a requester sees valid&ready in the same cycle
    assign req_ready_o = (state == IDLE) ? win_grant : '0;
    assign busy_o      = (state != IDLE);

    // Sequencer: latches the winner, strobes the write for exactly the ISSUE
    // cycle, samples readback on entry to RESP and holds the response until
    // the owner takes it. reg_wen_o defaults low so the strobe self-clears.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            owner_we    <= 1'b0;
            owner_addr  <= '0;
            wait_cnt    <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            reg_wen_o   <= '0;
            reg_wdata_o <= '0;
        end else begin
            reg_wen_o <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        owner      <= win_idx;
                        owner_we   <= win_we;
                        owner_addr <= win_addr;
                        rr_ptr     <= next_ptr;
                        state      <= ISSUE;
                        if (win_we && win_addr_ok) begin
                            reg_wen_o   <= NUM_REGS'(1) << win_addr;
                            reg_wdata_o <= win_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (!go_resp) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (!go_resp) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i[owner]) begin
                        state       <= IDLE;
                        rsp_valid_o <= '0;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                state       <= RESP;
                rsp_valid_o <= NUM_REQ'(1) << owner;
                rsp_rdata_o <= capture_data;
                rsp_err_o   <= !owner_addr_ok;
            end
        end
    end

endmodule

// File: tb/tb_custom_ip_reg_arbiter.sv
// Self-checking bench for custom_ip_reg_arbiter.
// A table of pending requests drives the requesters; expected winners,
// strobes and responses come from a transaction-level model (round-robin
// pointer as an integer, register contents as an array). A simple register
// file stands in for the IP and feeds reg_rdata_i.
module tb_custom_ip_reg_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int NUM_REGS = 3;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 2;
    localparam int RD_LAT   = 1;

    logic                       clk_i  = 1'b0;
    logic                       rst_ni = 1'b1;
    logic [NUM_REQ-1:0]         req_valid_i;
    logic [NUM_REQ-1:0]         req_ready_o;
    logic [NUM_REQ-1:0]         req_we_i;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr_i;
    logic [NUM_REQ*DATA_W-1:0]  req_wdata_i;
    logic [NUM_REQ-1:0]         rsp_valid_o;
    logic [NUM_REQ-1:0]         rsp_ready_i;
    logic [DATA_W-1:0]          rsp_rdata_o;
    logic                       rsp_err_o;
    logic [NUM_REGS-1:0]        reg_wen_o;
    logic [DATA_W-1:0]          reg_wdata_o;
    logic [NUM_REGS*DATA_W-1:0] reg_rdata_i;
    logic                       busy_o;

    int tests_run    = 0;
    int tests_failed = 0;

    // Request table: one outstanding request per requester
    logic              pending [NUM_REQ];
    logic              p_we    [NUM_REQ];
    logic [ADDR_W-1:0] p_addr  [NUM_REQ];
    logic [DATA_W-1:0] p_wdata [NUM_REQ];

    // Reference model state
    logic [DATA_W-1:0] ref_mem [NUM_REGS];
    int                rr_model;

    // Stand-in for the IP register file
    logic [DATA_W-1:0] ip_mem [NUM_REGS] = '{default: '0};

    custom_ip_reg_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .reg_wen_o   (reg_wen_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // IP registers take the strobed data at the clock edge
    always @(posedge clk_i) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reg_wen_o[r]) begin
                ip_mem[r] <= reg_wdata_o;
            end
        end
    end

    always_comb begin
        reg_rdata_i = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            reg_rdata_i[r*DATA_W +: DATA_W] = ip_mem[r];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive request lines from the request table
    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid_i[i]                   = pending[i];
            req_we_i[i]                      = p_we[i];
            req_addr_i[i*ADDR_W +: ADDR_W]   = p_addr[i];
            req_wdata_i[i*DATA_W +: DATA_W]  = p_wdata[i];
        end
    endtask

    task automatic setReq(input int i, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata);
        pending[i] = 1'b1;
        p_we[i]    = we;
        p_addr[i]  = addr;
        p_wdata[i] = wdata;
    endtask

    task automatic setRandomReq(input int i);
        setReq(i, 1'($urandom), ADDR_W'($urandom), $urandom);
    endtask

    function automatic bit anyPending();
        bit a = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pending[i]) a = 1'b1;
        end
        return a;
    endfunction

    task automatic checkResetState(input string pfx);
        checkOutput({pfx, "_req_ready"}, 64'(req_ready_o), 64'(0));
        checkOutput({pfx, "_rsp_valid"}, 64'(rsp_valid_o), 64'(0));
        checkOutput({pfx, "_rsp_rdata"}, 64'(rsp_rdata_o), 64'(0));
        checkOutput({pfx, "_rsp_err"},   64'(rsp_err_o),   64'(0));
        checkOutput({pfx, "_reg_wen"},   64'(reg_wen_o),   64'(0));
        checkOutput({pfx, "_reg_wdata"}, 64'(reg_wdata_o), 64'(0));
        checkOutput({pfx, "_busy"},      64'(busy_o),      64'(0));
    endtask

    task automatic doReset(input string pfx);
        for (int i = 0; i < NUM_REQ; i++) pending[i] = 1'b0;
        applyStimulus();
        rsp_ready_i = '0;
        rst_ni = 1'b0;
        #1;
        checkResetState(pfx);
        repeat (2) @(negedge clk_i);
        rst_ni   = 1'b1;
        rr_model = 0;
    endtask

    // One full transaction, starting with the DUT idle just after a falling edge.
    // The model picks the winner, then every phase is checked at its exact cycle.
    task automatic runTxn(input int hold);
        int                  w;
        int                  c;
        logic [NUM_REQ-1:0]  exp_grant;
        logic [NUM_REGS-1:0] exp_wen;
        logic [DATA_W-1:0]   exp_data;
        logic                exp_err;
        w = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = (rr_model + k) % NUM_REQ;
            if (w < 0 && pending[c]) w = c;
        end
        if (w < 0) return;
        exp_grant    = '0;
        exp_grant[w] = 1'b1;
        exp_err      = (int'(p_addr[w]) >= NUM_REGS);
        exp_wen      = '0;
        exp_data     = '0;
        if (p_we[w] && !exp_err) exp_wen[p_addr[w]] = 1'b1;
        if (!p_we[w] && !exp_err) exp_data = ref_mem[p_addr[w]];

        applyStimulus();
        #1;
        checkOutput("grant", 64'(req_ready_o), 64'(exp_grant));
        checkOutput("idle_busy", 64'(busy_o), 64'(0));

        @(negedge clk_i);
        pending[w] = 1'b0;
        applyStimulus();
        #1;
        checkOutput("strobe", 64'(reg_wen_o), 64'(exp_wen));
        if (exp_wen != '0) checkOutput("strobe_data", 64'(reg_wdata_o), 64'(p_wdata[w]));
        checkOutput("issue_ready", 64'(req_ready_o), 64'(0));
        checkOutput("issue_rsp", 64'(rsp_valid_o), 64'(0));
        checkOutput("issue_busy", 64'(busy_o), 64'(1));
        if (p_we[w] && !exp_err) ref_mem[p_addr[w]] = p_wdata[w];

        if (!p_we[w]) begin
            for (int i = 0; i < RD_LAT; i++) begin
                @(negedge clk_i);
                #1;
                checkOutput("wait_strobe", 64'(reg_wen_o), 64'(0));
                checkOutput("wait_rsp", 64'(rsp_valid_o), 64'(0));
            end
        end

        @(negedge clk_i);
        #1;
        checkOutput("rsp_valid", 64'(rsp_valid_o), 64'(exp_grant));
        checkOutput("rsp_rdata", 64'(rsp_rdata_o), 64'(exp_data));
        checkOutput("rsp_err", 64'(rsp_err_o), 64'(exp_err));
        checkOutput("rsp_strobe", 64'(reg_wen_o), 64'(0));

        // Non-owner rsp_ready bits are randomised; they must be ignored
        for (int h = 0; h < hold; h++) begin
            rsp_ready_i    = NUM_REQ'($urandom);
            rsp_ready_i[w] = 1'b0;
            @(negedge clk_i);
            #1;
            checkOutput("hold_valid", 64'(rsp_valid_o), 64'(exp_grant));
            checkOutput("hold_rdata", 64'(rsp_rdata_o), 64'(exp_data));
            checkOutput("hold_err", 64'(rsp_err_o), 64'(exp_err));
            checkOutput("hold_ready", 64'(req_ready_o), 64'(0));
        end

        rsp_ready_i    = NUM_REQ'($urandom);
        rsp_ready_i[w] = 1'b1;
        #1;
        checkOutput("resp_ready", 64'(req_ready_o), 64'(0));
        @(negedge clk_i);
        rsp_ready_i = '0;
        #1;
        checkOutput("done_valid", 64'(rsp_valid_o), 64'(0));
        checkOutput("done_busy", 64'(busy_o), 64'(0));
        rr_model = (w + 1) % NUM_REQ;
    endtask

    task automatic drainAll();
        while (anyPending()) runTxn($urandom_range(0, 2));
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pending[i] = 1'b0;
            p_we[i]    = 1'b0;
            p_addr[i]  = '0;
            p_wdata[i] = '0;
        end
        for (int r = 0; r < NUM_REGS; r++) ref_mem[r] = '0;
        rsp_ready_i = '0;
        applyStimulus();
        #2;
        doReset("por");

        // Single write, then read-after-write on reg2
        setReq(0, 1'b1, 2'd1, 32'hA5A5_0001);
        runTxn(0);
        setReq(0, 1'b1, 2'd2, 32'h0000_1234);
        runTxn(1);
        setReq(0, 1'b0, 2'd2, 32'h0);
        runTxn(0);

        // Continuous contention from a fresh pointer
        doReset("contend");
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pending[i]) setRandomReq(i);
            end
            runTxn($urandom_range(0, 2));
        end
        drainAll();

        // Out-of-range read
        setReq(1, 1'b0, 2'd3, 32'h0);
        runTxn(0);

        // Long response backpressure with a competing request waiting
        setReq(0, 1'b0, 2'd2, 32'h0);
        setReq(1, 1'b1, 2'd0, $urandom);
        runTxn(5);
        drainAll();

        // Reset while a read is waiting on readback
        setReq(0, 1'b0, 2'd2, 32'h0);
        applyStimulus();
        @(negedge clk_i);
        pending[0] = 1'b0;
        applyStimulus();
        @(negedge clk_i);
        #1;
        checkOutput("pre_reset_busy", 64'(busy_o), 64'(1));
        rst_ni = 1'b0;
        #1;
        checkResetState("mid_reset");
        @(negedge clk_i);
        rst_ni   = 1'b1;
        rr_model = 0;
        setReq(1, 1'b1, 2'd0, $urandom);
        runTxn(0);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pending[i] && ($urandom_range(0, 1) == 1)) setRandomReq(i);
            end
            if (!anyPending()) setRandomReq($urandom_range(0, NUM_REQ - 1));
            runTxn($urandom_range(0, 3));
        end
        drainAll();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
